// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle MIPS-subset CPU:
// FSM states, ALU ops, opcode/funct values, PC source select.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_SLT = 4'd2,
        ALU_AND = 4'd3,
        ALU_NOR = 4'd4,
        ALU_OR  = 4'd5,
        ALU_XOR = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_LUI = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,
        PC_BR  = 2'd1,
        PC_JMP = 2'd2
    } pc_src_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic alu_r;
        logic alu_i;
        logic load;
        logic store;
        logic beq;
        logic bne;
        logic jump;
        logic illegal;
    } inst_class_t;

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// Combinational instruction decoder (module ctrl_decode):
// instruction class plus the per-instruction datapath selects.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [31:0] inst,
    output inst_class_t cls,
    output alu_op_t     alu_op,
    output logic        alu_b_imm,
    output logic        imm_zext,
    output logic        rf_dst_rt,
    output logic        wb_mem
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_fields;

    assign op = inst[31:26];
    assign fn = inst[5:0];
    // Register and immediate fields feed the datapath only.
    assign unused_fields = ^inst[25:6];

    always_comb begin
        cls       = '0;
        alu_op    = ALU_ADD;
        alu_b_imm = 1'b0;
        imm_zext  = 1'b0;
        rf_dst_rt = 1'b0;
        wb_mem    = 1'b0;
        case (op)
            OP_RTYPE: begin
                cls.alu_r = 1'b1;
                case (fn)
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_AND:  alu_op = ALU_AND;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    default: begin
                        cls.alu_r   = 1'b0;
                        cls.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDIU: begin
                cls.alu_i = 1'b1;
                alu_b_imm = 1'b1;
                rf_dst_rt = 1'b1;
            end
            OP_LUI: begin
                cls.alu_i = 1'b1;
                alu_op    = ALU_LUI;
                alu_b_imm = 1'b1;
                imm_zext  = 1'b1;
                rf_dst_rt = 1'b1;
            end
            OP_LW: begin
                cls.load  = 1'b1;
                alu_b_imm = 1'b1;
                rf_dst_rt = 1'b1;
                wb_mem    = 1'b1;
            end
            OP_SW: begin
                cls.store = 1'b1;
                alu_b_imm = 1'b1;
            end
            OP_BEQ: begin
                cls.beq = 1'b1;
                alu_op  = ALU_SUB;
            end
            OP_BNE: begin
                cls.bne = 1'b1;
                alu_op  = ALU_SUB;
            end
            OP_J: cls.jump = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM and retired-instruction counter.
// MULTI_CYCLE_CTRL_STEP_EN adds a step input and a HALT after each retire.
module multi_cycle_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      inst,
    input  logic             rs_eq_rt,
`ifdef MULTI_CYCLE_CTRL_STEP_EN
    input  logic             step,
`endif
    output logic [2:0]       state,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [3:0]       alu_op,
    output logic             alu_b_imm,
    output logic             imm_zext,
    output logic             mem_we,
    output logic             rf_we,
    output logic             rf_dst_rt,
    output logic             wb_mem,
    output logic             inst_done,
    output logic             illegal,
    output logic [CNT_W-1:0] inst_cnt
);

`ifdef MULTI_CYCLE_CTRL_STEP_EN
    localparam state_t ST_RETIRE = ST_HALT;
`else
    localparam state_t ST_RETIRE = ST_IF;
`endif

    inst_class_t cls;
    alu_op_t     dec_alu_op;
    state_t      state_q;
    state_t      state_d;
    pc_src_t     pc_src_c;
    logic        ir_we_c;
    logic        pc_we_c;
    logic        mem_we_c;
    logic        rf_we_c;
    logic        done_c;
    logic        ill_c;
    logic        taken;

    ctrl_decode u_decode (
        .inst      (inst),
        .cls       (cls),
        .alu_op    (dec_alu_op),
        .alu_b_imm (alu_b_imm),
        .imm_zext  (imm_zext),
        .rf_dst_rt (rf_dst_rt),
        .wb_mem    (wb_mem)
    );

    assign taken = (cls.beq & rs_eq_rt) | (cls.bne & ~rs_eq_rt);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_src_c = PC_SEQ;
        ir_we_c  = 1'b0;
        pc_we_c  = 1'b0;
        mem_we_c = 1'b0;
        rf_we_c  = 1'b0;
        done_c   = 1'b0;
        ill_c    = 1'b0;
        case (state_q)
            ST_IF: begin
                ir_we_c = 1'b1;
                pc_we_c = 1'b1;
                state_d = ST_ID;
            end
            ST_ID: begin
                unique case (1'b1)
                    cls.jump: begin
                        pc_we_c  = 1'b1;
                        pc_src_c = PC_JMP;
                        done_c   = 1'b1;
                        state_d  = ST_RETIRE;
                    end
                    cls.illegal: begin
                        ill_c   = 1'b1;
                        state_d = ST_RETIRE;
                    end
                    default: state_d = ST_EX;
                endcase
            end
            ST_EX: begin
                unique case (1'b1)
                    cls.beq, cls.bne: begin
                        pc_we_c  = taken;
                        pc_src_c = PC_BR;
                        done_c   = 1'b1;
                        state_d  = ST_RETIRE;
                    end
                    cls.load, cls.store: state_d = ST_MEM;
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (cls.store) begin
                    mem_we_c = 1'b1;
                    done_c   = 1'b1;
                    state_d  = ST_RETIRE;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                rf_we_c = 1'b1;
                done_c  = 1'b1;
                state_d = ST_RETIRE;
            end
`ifdef MULTI_CYCLE_CTRL_STEP_EN
            ST_HALT: state_d = step ? ST_IF : ST_HALT;
`endif
            default: state_d = ST_IF;
        endcase
    end

    // Gate with resetn so nothing writes while reset is held low.
    assign ir_we     = ir_we_c & resetn;
    assign pc_we     = pc_we_c & resetn;
    assign mem_we    = mem_we_c & resetn;
    assign rf_we     = rf_we_c & resetn;
    assign inst_done = done_c & resetn;
    assign illegal   = ill_c & resetn;
    assign pc_src    = pc_src_c;
    assign alu_op    = dec_alu_op;
    assign state     = state_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_cnt <= '0;
        end else if (done_c) begin
            inst_cnt <= inst_cnt + CNT_W'(1);
        end
    end

endmodule
